ones_string_generator: RTL and testbench

//   Bit-serial generator of a test word that contains one string of consecutive ones.
//   The string is given by a run length and an LSB offset. The generated word drives

---
 rtl/ones_string_generator.sv | 148 ++++++++++++++
 tb/tb_ones_string_generator.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ones_string_generator.sv
// Bit-serial generator of a word holding one run of ones (run_len ones starting at bit offset).
// Optional self-measurement of the generated run is enabled with the ONES_GEN_CHECK_EN macro.
module ones_string_generator #(
   parameter int word_size    = 32,
   parameter int counter_size = 6
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [counter_size-1:0] run_len,
   input  logic [counter_size-1:0] offset,
   output logic [word_size-1:0]    word,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic                    check_ok,
   output logic [1:0]              state_o
);

   // Handshake: start is sampled only in IDLE/DONE; busy marks BUILD, done marks DONE,
   // and word/err/check_ok are valid and held stable for as long as done is high.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BUILD = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [counter_size:0]   WORD_SIZE_W = (counter_size+1)'(word_size);
   localparam logic [counter_size-1:0] LAST_IDX    = counter_size'(word_size - 1);

   state_t                  state_q;
   logic [word_size-1:0]    word_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    err_q;
   logic [word_size-2:0]    sreg_q;
   logic [counter_size-1:0] index_q;
   logic [counter_size-1:0] offset_q;
   logic [counter_size:0]   sum_q;

   logic [counter_size:0]   sum_d;
   logic                    bit_d;
   logic [word_size-1:0]    sreg_d;

   // Sum is one bit wider than the operands so an illegal request can never wrap into range.
   always_comb begin
      sum_d  = {1'b0, run_len} + {1'b0, offset};
      bit_d  = (index_q >= offset_q) && ({1'b0, index_q} < sum_q);
      sreg_d = {sreg_q, bit_d};
   end

`ifdef ONES_GEN_CHECK_EN
   logic [counter_size-1:0] run_len_q;
   logic [counter_size-1:0] run_q;
   logic [counter_size-1:0] max_q;
   logic                    check_ok_q;
   logic [counter_size-1:0] run_d;
   logic [counter_size-1:0] max_d;

   always_comb begin
      run_d = bit_d ? run_q + 1'b1 : '0;
      max_d = (run_d > max_q) ? run_d : max_q;
   end

   assign check_ok = check_ok_q;
`else
   assign check_ok = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         word_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         sreg_q   <= '0;
         index_q  <= '0;
         offset_q <= '0;
         sum_q    <= '0;
`ifdef ONES_GEN_CHECK_EN
         run_len_q  <= '0;
         run_q      <= '0;
         max_q      <= '0;
         check_ok_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  offset_q <= offset;
                  sum_q    <= sum_d;
`ifdef ONES_GEN_CHECK_EN
                  run_len_q  <= run_len;
                  run_q      <= '0;
                  max_q      <= '0;
                  check_ok_q <= 1'b0;
`endif
                  if (sum_d > WORD_SIZE_W) begin
                     state_q <= S_DONE;
                     err_q   <= 1'b1;
                     word_q  <= '0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_BUILD;
                     err_q   <= 1'b0;
                     index_q <= LAST_IDX;
                     sreg_q  <= '0;
                     busy_q  <= 1'b1;
                     done_q  <= 1'b0;
                  end
               end
            end
            S_BUILD: begin
               sreg_q <= sreg_d[word_size-2:0];
`ifdef ONES_GEN_CHECK_EN
               run_q <= run_d;
               max_q <= max_d;
`endif
               if (index_q == '0) begin
                  word_q  <= sreg_d;
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
`ifdef ONES_GEN_CHECK_EN
                  check_ok_q <= (max_d == run_len_q) && !err_q;
`endif
               end else begin
                  index_q <= index_q - 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign word    = word_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign err     = err_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_ones_string_generator.sv
// Scoreboard bench for ones_string_generator: driver pushes expected results, monitor pops on done.
module tb_ones_string_generator;

   localparam int WS = 32;
   localparam int CS = 6;
   localparam int W  = 48;  // {busy_cycles[47:40], run_len[39:34], err[33], check_ok[32], word[31:0]}

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [CS-1:0] run_len;
   logic [CS-1:0] offset;
   logic [WS-1:0] word;
   logic          busy;
   logic          done;
   logic          err;
   logic          check_ok;
   logic [1:0]    state_o;

   logic [W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   ones_string_generator #(.word_size(WS), .counter_size(CS)) dut (
      .clk(clk), .reset(reset), .start(start), .run_len(run_len), .offset(offset),
      .word(word), .busy(busy), .done(done), .err(err), .check_ok(check_ok), .state_o(state_o)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int max_run(input logic [WS-1:0] w);
      int r = 0;
      int m = 0;
      for (int i = 0; i < WS; i++) begin
         r = w[i] ? r + 1 : 0;
         if (r > m) m = r;
      end
      return m;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic issue(input int rl, input int off, input logic [WS-1:0] exp_word,
                        input logic exp_err, input logic push);
      logic exp_chk;
      logic [7:0] exp_busy;
`ifdef ONES_GEN_CHECK_EN
      exp_chk = !exp_err;
`else
      exp_chk = 1'b0;
`endif
      exp_busy = exp_err ? 8'd0 : 8'(WS);
      @(negedge clk);
      start   = 1'b1;
      run_len = CS'(rl);
      offset  = CS'(off);
      if (push) exp_q.push_back({exp_busy, CS'(rl), exp_err, exp_chk, exp_word});
      @(negedge clk);
      start = 1'b0;
      check("first_cycle_busy", busy, !exp_err);
      check("first_cycle_done", done, exp_err);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d results pending expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   initial begin
      int busy_cnt = 0;
      logic done_prev = 1'b0;
      logic [W-1:0] e;
      forever begin
         @(negedge clk);
         if (reset) begin
            busy_cnt  = 0;
            done_prev = 1'b0;
         end else begin
            if (busy) busy_cnt++;
            if (done && !done_prev) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done: word %0h with no request pending", word);
               end else begin
                  e = exp_q.pop_front();
                  check("word", word, e[31:0]);
                  check("check_ok", check_ok, e[32]);
                  check("err", err, e[33]);
                  check("busy_cycles", busy_cnt, e[47:40]);
                  check("max_run", max_run(word), e[33] ? 0 : int'(e[39:34]));
               end
               busy_cnt = 0;
            end
            done_prev = done;
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic seen_done;
      reset   = 1'b1;
      start   = 1'b0;
      run_len = '0;
      offset  = '0;
      repeat (2) @(negedge clk);
      check("rst_word", word, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_check_ok", check_ok, 0);
      check("rst_state", state_o, 0);
      reset = 1'b0;

      issue(5, 3, 32'h0000_00F8, 1'b0, 1'b1);  wait_drain();
      issue(32, 0, 32'hFFFF_FFFF, 1'b0, 1'b1); wait_drain();
      issue(0, 7, 32'h0000_0000, 1'b0, 1'b1);  wait_drain();
      issue(0, 32, 32'h0000_0000, 1'b0, 1'b1); wait_drain();
      issue(3, 29, 32'hE000_0000, 1'b0, 1'b1); wait_drain();

      do_reset();
      issue(10, 25, 32'h0, 1'b1, 1'b1); wait_drain();
      do_reset();
      issue(32, 1, 32'h0, 1'b1, 1'b1);  wait_drain();

      // start pulses during BUILD must not disturb the running build
      do_reset();
      issue(7, 4, 32'h0000_07F0, 1'b0, 1'b1);
      repeat (5) @(negedge clk);
      start = 1'b1; run_len = 6'd1; offset = 6'd0;
      @(negedge clk);
      start = 1'b0;
      wait_drain();

      // reset at BUILD cycle 10 abandons the build
      issue(9, 2, 32'h0, 1'b0, 1'b0);
      repeat (9) @(negedge clk);
      check("abort_busy_before", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_state", state_o, 0);
      check("abort_word", word, 0);
      check("abort_done", done, 0);
      check("abort_busy", busy, 0);
      seen_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      check("abort_no_done", seen_done, 0);

      // back-to-back restart from DONE
      issue(2, 0, 32'h0000_0003, 1'b0, 1'b1); wait_drain();
      check("done_held", done, 1);
      issue(1, 31, 32'h8000_0000, 1'b0, 1'b1); wait_drain();

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
